// File: rtl/i2c_mem_slave.sv
// I2C slave fronting a 128 x 8 byte memory; 7-bit address selects the byte, R/W picks store/return.
// Define I2C_MEM_AUTOINC_EN for multi-byte bursts with wrapping address increment.
module i2c_mem_slave #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  MEM_INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic [6:0] last_addr,
  output logic [7:0] last_data
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [7:0] mem_q [128] = '{default: MEM_INIT_VAL};

  // one extra stage beyond the synchroniser holds the previous sample for edge detection
  logic [SYNC_STAGES:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] addr_q, addr_d, addr_nxt;
  logic       rw_q, rw_d, ack_on_q, ack_on_d, lead_q, lead_d, wr_pend_q, wr_pend_d;
  logic       sda_oe_q, sda_oe_d, done_q, done_d;
  logic [6:0] last_addr_q, last_addr_d;
  logic [7:0] last_data_q, last_data_d;
  logic       mem_we;
  logic       scl_s, scl_p, sda_s, sda_p, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign scl_p     = scl_sync_q[SYNC_STAGES];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign sda_p     = sda_sync_q[SYNC_STAGES];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign addr_nxt  = addr_q + 7'd1;

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign last_addr = last_addr_q;
  assign last_data = last_data_q;

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-1:0], scl};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-1:0], sda};
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    ack_on_d    = ack_on_q;
    lead_d      = lead_q;
    wr_pend_d   = 1'b0;
    sda_oe_d    = sda_oe_q;
    done_d      = 1'b0;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    mem_we      = 1'b0;
    case (state_q)
      ADDR: if (scl_rise) begin
        sh_d  = {sh_q[6:0], sda_s};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          addr_d   = sh_q[6:0];
          rw_d     = sda_s;
          cnt_d    = '0;
          ack_on_d = 1'b0;
          state_d  = ADDR_ACK;
        end
      end
      ADDR_ACK, WR_ACK: if (scl_fall) begin
        if (!ack_on_q) begin
          sda_oe_d = 1'b1;
          ack_on_d = 1'b1;
        end else begin
          sda_oe_d = 1'b0;
          ack_on_d = 1'b0;
          cnt_d    = '0;
          if (state_q == ADDR_ACK) begin
            if (rw_q) begin
              sh_d     = mem_q[addr_q];
              sda_oe_d = ~mem_q[addr_q][7];
              state_d  = RD_DATA;
            end else begin
              state_d  = WR_DATA;
            end
          end else begin
`ifdef I2C_MEM_AUTOINC_EN
            addr_d  = addr_nxt;
            state_d = WR_DATA;
`else
            state_d = WAIT_STOP;
`endif
          end
        end
      end
      WR_DATA: begin
        // commit runs the clk after the 8th sample, even if STOP lands on that cycle
        if (wr_pend_q) begin
          mem_we      = 1'b1;
          done_d      = 1'b1;
          last_addr_d = addr_q;
          last_data_d = sh_q;
          state_d     = WR_ACK;
        end else if (scl_rise) begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d     = '0;
            wr_pend_d = 1'b1;
          end
        end
      end
      RD_DATA: if (scl_fall) begin
        if (lead_q) begin
          lead_d   = 1'b0;
          sda_oe_d = ~sh_q[7];
        end else if (cnt_q == 4'd7) begin
          cnt_d    = '0;
          sda_oe_d = 1'b0;
          state_d  = RD_ACK;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          sh_d     = {sh_q[6:0], 1'b0};
          sda_oe_d = ~sh_q[6];
        end
      end
      RD_ACK: if (scl_rise) begin
        done_d      = 1'b1;
        last_addr_d = addr_q;
        last_data_d = mem_q[addr_q];
`ifdef I2C_MEM_AUTOINC_EN
        if (!sda_s) begin
          addr_d  = addr_nxt;
          sh_d    = mem_q[addr_nxt];
          lead_d  = 1'b1;
          state_d = RD_DATA;
        end else begin
          state_d = WAIT_STOP;
        end
`else
        state_d = WAIT_STOP;
`endif
      end
      default: ;
    endcase
    if (stop_det || start_det) begin
      state_d   = stop_det ? IDLE : ADDR;
      sda_oe_d  = 1'b0;
      cnt_d     = '0;
      ack_on_d  = 1'b0;
      lead_d    = 1'b0;
      wr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      lead_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      ack_on_q    <= ack_on_d;
      lead_q      <= lead_d;
      wr_pend_q   <= wr_pend_d;
      sda_oe_q    <= sda_oe_d;
      done_q      <= done_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= sh_q;
  end

endmodule
